// File: rtl/axi_lite_regs_pkg.sv
// axi_lite_regs_pkg: register word indexes, response codes, FSM states and byte-strobe merge.
package axi_lite_regs_pkg;
  localparam logic [3:0] REG_ID         = 4'h0;
  localparam logic [3:0] REG_SCRATCH    = 4'h1;
  localparam logic [3:0] REG_GPIO_OUT   = 4'h2;
  localparam logic [3:0] REG_GPIO_IN    = 4'h3;
  localparam logic [3:0] REG_IRQ_STATUS = 4'h4;
  localparam logic [3:0] REG_IRQ_MASK   = 4'h5;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/axi_lite_regs_sync.sv
// axi_lite_regs_sync: two-flop synchronizer for the GPIO inputs.
module axi_lite_regs_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk)
    if (reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/axi_lite_regs.sv
// axi_lite_regs: AXI-Lite register block (ID, scratch, GPIO); IRQ logic enabled by AXI_LITE_REGS_IRQ_EN.
module axi_lite_regs
  import axi_lite_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          GPIO_WIDTH = 16,
  parameter logic [31:0] ID_VALUE   = 32'h52554646
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic                  irq
);
`ifdef AXI_LITE_REGS_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  w_state_t w_state;
  r_state_t r_state;
  logic [31:0] scratch, r_val;
  logic [GPIO_WIDTH-1:0] gpio_in, irq_status, irq_mask;
  logic [3:0] w_idx, r_idx;
  logic w_ok, r_ok, w_ack;
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[ADDR_WIDTH-1:6], s_axi_awaddr[1:0],
                       s_axi_araddr[ADDR_WIDTH-1:6], s_axi_araddr[1:0]};
  assign w_idx = s_axi_awaddr[5:2];
  assign r_idx = s_axi_araddr[5:2];
  assign w_ack = w_state == W_ACK;
  assign w_ok = w_idx == REG_SCRATCH || w_idx == REG_GPIO_OUT ||
                (IRQ_EN && (w_idx == REG_IRQ_STATUS || w_idx == REG_IRQ_MASK));
  assign r_ok = r_idx <= REG_GPIO_IN || (IRQ_EN && (r_idx == REG_IRQ_STATUS || r_idx == REG_IRQ_MASK));
  always_comb
    r_val = !r_ok                   ? '0 :
            r_idx == REG_ID         ? ID_VALUE :
            r_idx == REG_SCRATCH    ? scratch :
            r_idx == REG_GPIO_OUT   ? 32'(gpio_o) :
            r_idx == REG_GPIO_IN    ? 32'(gpio_in) :
            r_idx == REG_IRQ_STATUS ? 32'(irq_status) :
            r_idx == REG_IRQ_MASK   ? 32'(irq_mask) : '0;
  axi_lite_regs_sync #(.WIDTH(GPIO_WIDTH)) u_sync (.clk(clk), .reset(reset), .d(gpio_i), .q(gpio_in));
  always_ff @(posedge clk)
    if (reset) begin
      w_state <= W_IDLE;
      {s_axi_awready, s_axi_wready, s_axi_bvalid} <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else
      case (w_state)
        W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
          w_state <= W_ACK;
          {s_axi_awready, s_axi_wready} <= 2'b11;
        end
        W_ACK: begin
          w_state <= W_RESP;
          {s_axi_awready, s_axi_wready} <= 2'b00;
          s_axi_bvalid <= 1'b1;
          s_axi_bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
        end
        W_RESP: if (s_axi_bready) begin
          w_state <= W_IDLE;
          s_axi_bvalid <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
  // rdata is sampled from current register values, so a same-edge write is not yet visible
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= R_IDLE;
      {s_axi_arready, s_axi_rvalid} <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          r_state <= R_ADDR;
          s_axi_arready <= 1'b1;
        end
        R_ADDR: begin
          r_state <= R_DATA;
          s_axi_arready <= 1'b0;
          s_axi_rvalid <= 1'b1;
          s_axi_rdata <= r_val;
          s_axi_rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
        end
        R_DATA: if (s_axi_rready) begin
          r_state <= R_IDLE;
          s_axi_rvalid <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
  always_ff @(posedge clk)
    if (reset) begin
      scratch <= '0;
      gpio_o <= '0;
    end else if (w_ack) begin
      if (w_idx == REG_SCRATCH) scratch <= apply_strb(scratch, s_axi_wdata, s_axi_wstrb);
      if (w_idx == REG_GPIO_OUT) gpio_o <= GPIO_WIDTH'(apply_strb(32'(gpio_o), s_axi_wdata, s_axi_wstrb));
    end
`ifdef AXI_LITE_REGS_IRQ_EN
  logic [GPIO_WIDTH-1:0] gpio_prev, irq_clr;
  assign irq_clr = (w_ack && w_idx == REG_IRQ_STATUS) ? GPIO_WIDTH'(apply_strb('0, s_axi_wdata, s_axi_wstrb)) : '0;
  // the set term is OR-ed after the clear so a simultaneous edge wins
  always_ff @(posedge clk)
    if (reset) begin
      {gpio_prev, irq_status, irq_mask} <= '0;
      irq <= 1'b0;
    end else begin
      gpio_prev <= gpio_in;
      irq_status <= (irq_status & ~irq_clr) | (gpio_in & ~gpio_prev);
      if (w_ack && w_idx == REG_IRQ_MASK)
        irq_mask <= GPIO_WIDTH'(apply_strb(32'(irq_mask), s_axi_wdata, s_axi_wstrb));
      irq <= |(irq_status & irq_mask);
    end
`else
  assign irq_status = '0;
  assign irq_mask = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_regs.sv
// tb_axi_lite_regs: directed bench with a response scoreboard for axi_lite_regs (AXI_LITE_REGS_IRQ_EN aware).
module tb_axi_lite_regs;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready, irq;
  logic [1:0] bresp, rresp;
  logic [15:0] gpio_i, gpio_o;
  int errors = 0;
  int checks = 0;
  logic [31:0] rq_data[$];
  logic [1:0] rq_resp[$];
  logic [1:0] bq_resp[$];

  axi_lite_regs dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
    int lat;
    rq_data.push_back(exp_data);
    rq_resp.push_back(exp_resp);
    araddr = addr;
    arvalid = 1'b1;
    rready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rvalid && lat < 10);
    arvalid = 1'b0;
    chk({tag, "_rlat"}, lat, 2);
    chk({tag, "_rdata"}, rdata, rq_data.pop_front());
    chk({tag, "_rresp"}, 32'(rresp), 32'(rq_resp.pop_front()));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({tag, "_rvalid_drop"}, 32'(rvalid), 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input int hold, input string tag);
    int lat, held;
    bq_resp.push_back(exp_resp);
    awaddr = addr;
    wdata = data;
    wstrb = strb;
    awvalid = 1'b1;
    wvalid = 1'b1;
    bready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bvalid && lat < 10);
    {awvalid, wvalid} = 2'b00;
    chk({tag, "_blat"}, lat, 2);
    chk({tag, "_bresp"}, 32'(bresp), 32'(bq_resp.pop_front()));
    held = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bvalid && bresp === exp_resp) held++;
    end
    if (hold > 0) chk({tag, "_bhold"}, held, hold);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(bvalid), 0);
  endtask

  initial begin
    int seen, stray;
    reset = 1'b1;
    {awaddr, wdata, araddr} = '0;
    {awprot, arprot} = '0;
    wstrb = 4'h0;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    gpio_i = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid}, 0);
    chk("rst_resp_data", {rdata, bresp, rresp} == 36'h0, 1);
    chk("rst_gpio_o", gpio_o, 0);
    chk("rst_irq", irq, 0);

    do_read(32'h00, 32'h52554646, 2'b00, "id");
    do_write(32'h04, 32'hDEADBEEF, 4'b0011, 2'b00, 0, "scr_w");
    do_read(32'h04, 32'h0000BEEF, 2'b00, "scr_r");
    do_write(32'h04, 32'h12345678, 4'b0000, 2'b00, 0, "scr_nostrb");
    do_read(32'h04, 32'h0000BEEF, 2'b00, "scr_nostrb_r");
    do_read(32'h44, 32'h0000BEEF, 2'b00, "alias");
    do_write(32'h08, 32'h0000A5A5, 4'b1111, 2'b00, 5, "gpo_w");
    chk("gpio_o", gpio_o, 16'hA5A5);
    do_read(32'h08, 32'h0000A5A5, 2'b00, "gpo_r");
    do_write(32'h00, 32'hFFFFFFFF, 4'b1111, 2'b10, 0, "ro_w");
    do_read(32'h3C, 32'h0, 2'b10, "unmapped");
    do_read(32'h00, 32'h52554646, 2'b00, "id_again");

    gpio_i = 16'h1234;
    repeat (3) @(negedge clk);
    do_read(32'h0C, 32'h00001234, 2'b00, "gpi");

    awaddr = 32'h04;
    awvalid = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (awready || wready || bvalid) seen++;
    end
    awvalid = 1'b0;
    chk("aw_only_wait", seen, 0);

`ifdef AXI_LITE_REGS_IRQ_EN
    do_write(32'h14, 32'h1, 4'b1111, 2'b00, 0, "mask_w");
    chk("irq_masked_off", irq, 0);
    gpio_i = 16'h1235;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (irq) seen = 1;
    end
    chk("irq_rise", seen, 1);
    do_write(32'h10, 32'h1, 4'b1111, 2'b00, 0, "stat_clr");
    chk("irq_cleared", irq, 0);
    do_read(32'h10, 32'h00001234, 2'b00, "stat_r");
`else
    do_write(32'h14, 32'h1, 4'b1111, 2'b10, 0, "mask_unmapped");
    do_read(32'h10, 32'h0, 2'b10, "stat_unmapped");
    gpio_i = 16'h1235;
    repeat (5) @(negedge clk);
    chk("irq_const0", irq, 0);
`endif

    araddr = 32'h04;
    arvalid = 1'b1;
    seen = 0;
    do begin
      @(negedge clk);
      seen++;
    end while (!rvalid && seen < 10);
    chk("rst_rd_pending", rvalid, 1);
    arvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rd_drop", rvalid, 0);
    reset = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid) stray++;
    end
    chk("rst_rd_no_late", stray, 0);
    chk("rst_irq_after", irq, 0);
    do_read(32'h04, 32'h0, 2'b00, "scr_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_regs.md
AXI_LITE_REGS -- requirements
Module: axi_lite_regs

Interface
- REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the AXI-Lite address width.
- REQ-002 The block SHALL have parameter GPIO_WIDTH, default 16, the width of the GPIO in/out ports (1..32).
- REQ-003 The block SHALL have parameter ID_VALUE, default 32'h52554646, the constant returned by the ID register.
- REQ-004 Port `clk`, input, 1 bit: the single clock. All logic is on its rising edge.
- REQ-005 Port `reset`, input, 1 bit: synchronous, active-high reset.
- REQ-006 AXI-Lite write-address ports: `s_axi_awaddr` (in, ADDR_WIDTH), `s_axi_awprot` (in, 3, ignored), `s_axi_awvalid` (in, 1), `s_axi_awready` (out, 1).
- REQ-007 AXI-Lite write-data ports: `s_axi_wdata` (in, 32), `s_axi_wstrb` (in, 4), `s_axi_wvalid` (in, 1), `s_axi_wready` (out, 1).
- REQ-008 AXI-Lite write-response ports: `s_axi_bresp` (out, 2), `s_axi_bvalid` (out, 1), `s_axi_bready` (in, 1).
- REQ-009 AXI-Lite read-address ports: `s_axi_araddr` (in, ADDR_WIDTH), `s_axi_arprot` (in, 3, ignored), `s_axi_arvalid` (in, 1), `s_axi_arready` (out, 1).
- REQ-010 AXI-Lite read-data ports: `s_axi_rdata` (out, 32), `s_axi_rresp` (out, 2), `s_axi_rvalid` (out, 1), `s_axi_rready` (in, 1).
- REQ-011 Port `gpio_i`, input, GPIO_WIDTH: asynchronous inputs (switches).
- REQ-012 Port `gpio_o`, output, GPIO_WIDTH: the GPIO_OUT register, driving LEDs.
- REQ-013 Port `irq`, output, 1 bit: level interrupt.

Function
- REQ-014 Register decode SHALL use `addr[5:2]`. Map:
  - 0x00 ID (RO, ID_VALUE)
  - 0x04 SCRATCH (RW)
  - 0x08 GPIO_OUT (RW, low GPIO_WIDTH bits)
  - 0x0C GPIO_IN (RO)
  - 0x10 IRQ_STATUS (W1C)
  - 0x14 IRQ_MASK (RW)
- REQ-015 Address bits above bit 5 SHALL be ignored, so the map aliases.
- REQ-016 Register bits above GPIO_WIDTH SHALL read 0.
- REQ-017 The write FSM SHALL have states W_IDLE -> W_ACK -> W_RESP -> W_IDLE.
  - W_IDLE -> W_ACK when `awvalid` and `wvalid` are both high.
  - W_ACK lasts one cycle with `awready` = `wready` = 1, and the register commits on that edge.
  - W_RESP holds `bvalid` = 1 until `bready`; `bvalid` and `bresp` are stable while waiting.
- REQ-018 Writes SHALL be byte-enabled by `wstrb`. A strobe of 4'b0000 commits nothing and returns OKAY.
- REQ-019 A write to a RO or unmapped address SHALL be discarded with `bresp` = 2'b10 (SLVERR). Otherwise `bresp` = 2'b00.
- REQ-020 The read FSM SHALL have states R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_ADDR is one cycle with `arready` = 1, and `rdata` is captured there.
  - R_DATA holds `rvalid` until `rready`, with `rdata` and `rresp` stable.
- REQ-021 Read latency from `arvalid` to `rvalid` SHALL be 2 cycles, and write latency from `awvalid`&`wvalid` to `bvalid` SHALL be 2 cycles.
- REQ-022 An unmapped read SHALL return `rdata` = 0 with `rresp` = 2'b10.
- REQ-023 The read and write FSMs SHALL be independent. If a read capture and a write commit fall on the same edge, the read SHALL return the pre-write value.
- REQ-024 `awvalid` without `wvalid` (or the reverse) SHALL wait in W_IDLE indefinitely with both readys low.
- REQ-025 GPIO_IN SHALL be a two-flop synchronizer of `gpio_i`, giving a 2-cycle latency.
- REQ-026 `gpio_o` SHALL be driven directly from the GPIO_OUT register, so an update is visible the cycle after W_ACK.

Reset
- REQ-027 On `reset`, both FSMs SHALL go to idle.
- REQ-028 On `reset`, all readys and valids SHALL be 0, `bresp`/`rresp`/`rdata` SHALL be 0, and SCRATCH, GPIO_OUT, IRQ_STATUS, IRQ_MASK, the synchronizers and `irq` SHALL all be 0.
- REQ-029 A reset during W_RESP or R_DATA SHALL drop the pending response. No response is issued afterwards.

Configuration
- REQ-030 Macro AXI_LITE_REGS_IRQ_EN defined:
  - a rising edge on any synchronized GPIO_IN bit SHALL set the matching IRQ_STATUS bit;
  - writing 1 clears a status bit;
  - if a set and a clear hit the same bit in the same cycle, the set wins;
  - `irq` = |(IRQ_STATUS & IRQ_MASK), registered, for a 1-cycle latency.
- REQ-031 Macro AXI_LITE_REGS_IRQ_EN undefined:
  - 0x10 and 0x14 SHALL be unmapped (SLVERR);
  - `irq` SHALL be a constant 0;
  - no edge-detect logic SHALL be present.

Structure
- REQ-032 Shared package `axi_lite_regs_pkg` SHALL hold the register offset constants, the RESP_OKAY/RESP_SLVERR constants, and the write/read FSM state typedefs.
- REQ-033 Sub-module `axi_lite_regs_sync` SHALL implement the GPIO_WIDTH-wide two-flop synchronizer. Everything else stays flat.

Verification
- REQ-034 Reset, then read 0x00 -> `rdata` = 32'h52554646, `rresp` = 00, `rvalid` exactly 2 cycles after `arvalid`.
- REQ-035 Write 0x04 = 32'hDEADBEEF with `wstrb` = 4'b0011, read back -> 32'h0000BEEF.
- REQ-036 Write 0x08 = 32'h0000A5A5 with `bready` held low for 5 cycles -> `bvalid` held 5 cycles, `gpio_o` = 16'hA5A5 after W_ACK.
- REQ-037 Write 0x00, then read 0x3C -> `bresp` = 10, `rresp` = 10 with `rdata` = 0, and ID unchanged.
- REQ-038 IRQ_EN build: set IRQ_MASK = 0x1, toggle `gpio_i[0]` 0->1 -> `irq` = 1 within 4 cycles; write 0x10 = 0x1 -> `irq` = 0.
- REQ-039 Assert `reset` while `rvalid` is pending -> `rvalid` = 0 the next cycle, and no later `rvalid`.
